// File: rtl/best_1ofn_busy_pipe.sv
// best_1ofn_busy_pipe: pipelined best-of-N pattern selector with busy skip.
// Inputs are registered (S0), a registered binary tournament tree of depth
// D = ceil(log2 NCH) picks the highest-ranked non-busy channel (ties go to
// the lowest index), and a final stage emits the winner with its extended
// key {idx,key} and a region-clamped sub-strip key. Latency is D+2 clocks.
// Build option SORT_ON_QLT_EN: rank on quality instead of pattern id
// (pattern bit 0, the bend direction, is never ranked on).
module best_1ofn_busy_pipe #(
    parameter int NCH        = 7,
    parameter int IDXB       = 3,
    parameter int MXPATB     = 7,
    parameter int MXKEYB     = 5,
    parameter int MXKEYBX    = 8,
    parameter int MXOFFSB    = 4,
    parameter int MXQLTB     = 6,
    parameter int MXBNDB     = 5,
    parameter int MXPATC     = 12,
    parameter int MXSUBKEYBX = 10,
    parameter int SPLIT_KEY  = 128,
    parameter int KEY_MAX    = 223
) (
    input  logic                      clock,
    input  logic                      global_reset,
    input  logic                      valid_in,
    input  logic [NCH*MXPATB-1:0]     pat,
    input  logic [NCH*MXKEYB-1:0]     key,
    input  logic [NCH*MXOFFSB-1:0]    offs,
    input  logic [NCH*MXQLTB-1:0]     qlt,
    input  logic [NCH*MXBNDB-1:0]     bend,
    input  logic [NCH*MXPATC-1:0]     carry,
    input  logic [NCH-1:0]            bsy,
    output logic                      valid_out,
    output logic [MXPATB-1:0]         best_pat,
    output logic [MXKEYBX-1:0]        best_key,
    output logic [MXQLTB-1:0]         best_qlt,
    output logic [MXBNDB-1:0]         best_bend,
    output logic [MXPATC-1:0]         best_carry,
    output logic [MXSUBKEYBX-1:0]     best_subkey,
    output logic                      best_bsy
);

    localparam int D  = $clog2(NCH);
    localparam int NP = 1 << D;
    localparam int RW = MXSUBKEYBX + 2;

`ifdef SORT_ON_QLT_EN
    localparam int SORTB = MXQLTB;
`else
    localparam int SORTB = MXPATB - 1;
`endif

    // Clamp windows for the lower and upper key regions.
    localparam logic signed [RW-1:0] LO_A = RW'(0);
    localparam logic signed [RW-1:0] HI_A = RW'(4 * SPLIT_KEY - 1);
    localparam logic signed [RW-1:0] LO_B = RW'(4 * SPLIT_KEY);
    localparam logic signed [RW-1:0] HI_B = RW'(4 * KEY_MAX + 3);

    typedef struct packed {
        logic                live;
        logic [SORTB-1:0]    sort;
        logic [IDXB-1:0]     idx;
        logic [MXPATB-1:0]   pat;
        logic [MXKEYB-1:0]   key;
        logic [MXOFFSB-1:0]  offs;
        logic [MXQLTB-1:0]   qlt;
        logic [MXBNDB-1:0]   bend;
        logic [MXPATC-1:0]   carry;
    } node_t;

    // One tournament match: b takes the slot only if it is live and strictly
    // better, so equal ranks keep the lower-index side.
    function automatic node_t pick(input node_t a, input node_t b);
        node_t r;
        if (b.live && (!a.live || (b.sort > a.sort))) begin
            r = b;
        end else begin
            r = a;
        end
        r.live = a.live | b.live;
        return r;
    endfunction

    node_t                  in_nodes_s [NP];
    node_t                  tree_r     [D+1][NP];
    logic [D:0]             vld_r;
    logic [MXKEYBX-1:0]     ext_s;
    logic signed [RW-1:0]   raw_s;
    logic signed [RW-1:0]   lo_s;
    logic signed [RW-1:0]   hi_s;
    logic signed [RW-1:0]   clamp_s;

    // Unpack the candidate buses into tree leaves; padding leaves are never live.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            in_nodes_s[i] = '0;
            if (i < NCH) begin
                in_nodes_s[i].live  = ~bsy[i];
`ifdef SORT_ON_QLT_EN
                in_nodes_s[i].sort  = qlt[i*MXQLTB +: MXQLTB];
`else
                in_nodes_s[i].sort  = pat[i*MXPATB+1 +: SORTB];
`endif
                in_nodes_s[i].idx   = IDXB'(i);
                in_nodes_s[i].pat   = pat[i*MXPATB +: MXPATB];
                in_nodes_s[i].key   = key[i*MXKEYB +: MXKEYB];
                in_nodes_s[i].offs  = offs[i*MXOFFSB +: MXOFFSB];
                in_nodes_s[i].qlt   = qlt[i*MXQLTB +: MXQLTB];
                in_nodes_s[i].bend  = bend[i*MXBNDB +: MXBNDB];
                in_nodes_s[i].carry = carry[i*MXPATC +: MXPATC];
            end else begin
                in_nodes_s[i] = '0;
            end
        end
    end

    // Input register (level 0) and registered tournament levels 1..D, with valid alongside.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            vld_r <= '0;
            for (int l = 0; l <= D; l++) begin
                for (int j = 0; j < NP; j++) begin
                    tree_r[l][j] <= '0;
                end
            end
        end else begin
            vld_r[0] <= valid_in;
            for (int j = 0; j < NP; j++) begin
                tree_r[0][j] <= in_nodes_s[j];
            end
            for (int l = 1; l <= D; l++) begin
                vld_r[l] <= vld_r[l-1];
                for (int j = 0; j < NP / 2; j++) begin
                    tree_r[l][j] <= (j < (NP >> l)) ? pick(tree_r[l-1][2*j], tree_r[l-1][2*j+1]) : '0;
                end
                for (int j = NP / 2; j < NP; j++) begin
                    tree_r[l][j] <= '0;
                end
            end
        end
    end

    // Sub-strip key: 4*key + signed offset, clamped to the winner's key region.
    always_comb begin
        ext_s = {tree_r[D][0].idx, tree_r[D][0].key};
        raw_s = $signed({{(RW-MXKEYBX-2){1'b0}}, ext_s, 2'b00})
              + $signed({{(RW-MXOFFSB){tree_r[D][0].offs[MXOFFSB-1]}}, tree_r[D][0].offs});
        if (ext_s < MXKEYBX'(SPLIT_KEY)) begin
            lo_s = LO_A;
            hi_s = HI_A;
        end else begin
            lo_s = LO_B;
            hi_s = HI_B;
        end
        if (raw_s < lo_s) begin
            clamp_s = lo_s;
        end else if (raw_s > hi_s) begin
            clamp_s = hi_s;
        end else begin
            clamp_s = raw_s;
        end
    end

    // Output register: data only for a valid crossing with a live winner.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            valid_out   <= 1'b0;
            best_pat    <= '0;
            best_key    <= '0;
            best_qlt    <= '0;
            best_bend   <= '0;
            best_carry  <= '0;
            best_subkey <= '0;
            best_bsy    <= 1'b0;
        end else if (vld_r[D] && tree_r[D][0].live) begin
            valid_out   <= 1'b1;
            best_pat    <= tree_r[D][0].pat;
            best_key    <= ext_s;
            best_qlt    <= tree_r[D][0].qlt;
            best_bend   <= tree_r[D][0].bend;
            best_carry  <= tree_r[D][0].carry;
            best_subkey <= clamp_s[MXSUBKEYBX-1:0];
            best_bsy    <= 1'b0;
        end else begin
            valid_out   <= vld_r[D];
            best_pat    <= '0;
            best_key    <= '0;
            best_qlt    <= '0;
            best_bend   <= '0;
            best_carry  <= '0;
            best_subkey <= '0;
            best_bsy    <= vld_r[D];
        end
    end

endmodule

// File: tb/tb_best_1ofn_busy_pipe.sv
// Bench for best_1ofn_busy_pipe (NCH=7, latency 5): directed table of
// hand-computed vectors streamed back-to-back, random streaming against a
// linear-scan reference model, and reset with crossings in flight.
module tb_best_1ofn_busy_pipe;

    localparam int NCH = 7;
    localparam int LAT = 5;
`ifdef SORT_ON_QLT_EN
    localparam bit QSORT = 1'b1;
`else
    localparam bit QSORT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          global_reset;
    logic          valid_in;
    logic [48:0]   pat;
    logic [34:0]   key;
    logic [27:0]   offs;
    logic [41:0]   qlt;
    logic [34:0]   bend;
    logic [83:0]   carry;
    logic [6:0]    bsy;
    logic          valid_out;
    logic [6:0]    best_pat;
    logic [7:0]    best_key;
    logic [5:0]    best_qlt;
    logic [4:0]    best_bend;
    logic [11:0]   best_carry;
    logic [9:0]    best_subkey;
    logic          best_bsy;

    always #5 clock = ~clock;

    best_1ofn_busy_pipe dut (
        .clock(clock), .global_reset(global_reset), .valid_in(valid_in),
        .pat(pat), .key(key), .offs(offs), .qlt(qlt), .bend(bend),
        .carry(carry), .bsy(bsy), .valid_out(valid_out), .best_pat(best_pat),
        .best_key(best_key), .best_qlt(best_qlt), .best_bend(best_bend),
        .best_carry(best_carry), .best_subkey(best_subkey), .best_bsy(best_bsy)
    );

    typedef struct packed {
        logic        vld;
        logic        bsy;
        logic [6:0]  pat;
        logic [7:0]  key;
        logic [5:0]  qlt;
        logic [4:0]  bend;
        logic [11:0] carry;
        logic [9:0]  sub;
    } exp_t;

    typedef struct {
        exp_t  v;
        string nm;
    } ent_t;

    typedef struct {
        string            nm;
        logic             vin;
        logic [6:0]       bsy;
        logic [41:0]      p6;
        int               och;
        logic [4:0]       okey;
        logic signed [3:0] ooffs;
        int               eidx;
        logic             ebsy;
        logic [7:0]       ekey;
        logic [9:0]       esub;
    } vec_t;

    ent_t q[$];
    int   nvec  = 0;
    int   nfail = 0;

    function automatic logic [41:0] mk6(input int a0, a1, a2, a3, a4, a5, a6);
        logic [41:0] r;
        r = {6'(a6), 6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
        return r;
    endfunction

    // Reference: linear scan, strict > so the lowest index wins ties.
    function automatic exp_t model();
        exp_t e;
        int best, bs, s, ext, raw;
        e = '0;
        best = -1;
        bs = 0;
        for (int i = 0; i < NCH; i++) begin
            if (QSORT) s = int'(qlt[i*6 +: 6]);
            else       s = int'(pat[i*7+1 +: 6]);
            if (!bsy[i] && (best < 0 || s > bs)) begin
                best = i;
                bs = s;
            end
        end
        if (!valid_in) return e;
        e.vld = 1'b1;
        if (best < 0) begin
            e.bsy = 1'b1;
            return e;
        end
        ext = best * 32 + int'(key[best*5 +: 5]);
        raw = 4 * ext + int'($signed(offs[best*4 +: 4]));
        if (ext < 128) raw = (raw < 0) ? 0 : ((raw > 511) ? 511 : raw);
        else           raw = (raw < 512) ? 512 : ((raw > 895) ? 895 : raw);
        e.pat   = pat[best*7 +: 7];
        e.key   = 8'(ext);
        e.qlt   = qlt[best*6 +: 6];
        e.bend  = bend[best*5 +: 5];
        e.carry = carry[best*12 +: 12];
        e.sub   = 10'(raw);
        return e;
    endfunction

    // Apply current inputs for one clock and check the output due this cycle.
    task automatic step(input exp_t e, input bit rst, input string nm);
        ent_t en;
        exp_t got;
        global_reset = rst;
        if (!rst) begin
            en.v = e;
            en.nm = nm;
            q.push_back(en);
        end
        @(posedge clock);
        #1;
        if (rst) begin
            en.v = '0;
            en.nm = nm;
            q.delete();
            for (int k = 0; k < LAT - 1; k++) q.push_back('{v: '0, nm: "flush"});
        end else begin
            en = q.pop_front();
        end
        got = {valid_out, best_bsy, best_pat, best_key, best_qlt, best_bend, best_carry, best_subkey};
        nvec++;
        if (got !== en.v) begin
            nfail++;
            $display("FAIL %s: actual vld=%0b bsy=%0b pat=%0d key=%0d qlt=%0d bend=%0d carry=%0d sub=%0d, required vld=%0b bsy=%0b pat=%0d key=%0d qlt=%0d bend=%0d carry=%0d sub=%0d",
                     en.nm, got.vld, got.bsy, got.pat, got.key, got.qlt, got.bend, got.carry, got.sub,
                     en.v.vld, en.v.bsy, en.v.pat, en.v.key, en.v.qlt, en.v.bend, en.v.carry, en.v.sub);
        end
    endtask

    // Fixed per-channel background data with an optional key/offset override.
    task automatic drive_base(input logic vin, input logic [6:0] b, input logic [41:0] p6,
                              input int och, input logic [4:0] okey, input logic signed [3:0] ooffs);
        valid_in = vin;
        bsy = b;
        for (int i = 0; i < NCH; i++) begin
            pat[i*7 +: 7]    = {p6[i*6 +: 6], 1'(i % 2)};
            key[i*5 +: 5]    = 5'(3 * i + 4);
            offs[i*4 +: 4]   = 4'd0;
            qlt[i*6 +: 6]    = 6'(10 + i);
            bend[i*5 +: 5]   = 5'(i + 1);
            carry[i*12 +: 12] = 12'(100 * i + 7);
        end
        if (och >= 0) begin
            key[och*5 +: 5]  = okey;
            offs[och*4 +: 4] = ooffs;
        end
    endtask

    task automatic drive_rand();
        int r;
        valid_in = ($urandom_range(0, 9) != 0);
        pat   = 49'({$urandom(), $urandom()});
        key   = 35'({$urandom(), $urandom()});
        offs  = 28'($urandom());
        qlt   = 42'({$urandom(), $urandom()});
        bend  = 35'({$urandom(), $urandom()});
        carry = 84'({$urandom(), $urandom(), $urandom()});
        r = $urandom_range(0, 7);
        if (r == 0)      bsy = 7'h7f;
        else if (r == 1) bsy = 7'h00;
        else             bsy = 7'($urandom());
    endtask

    vec_t tbl[12];

    initial begin
        exp_t e;
        tbl[0]  = '{"prio_tie",   1'b1, 7'b0000000, mk6(5,9,9,3,9,1,0), -1, 5'd0, 4'sd0,
                    QSORT ? 6 : 1, 1'b0, QSORT ? 8'd214 : 8'd39, QSORT ? 10'd856 : 10'd156};
        tbl[1]  = '{"busy_skip",  1'b1, 7'b0000110, mk6(5,9,9,3,9,1,0), -1, 5'd0, 4'sd0,
                    QSORT ? 6 : 4, 1'b0, QSORT ? 8'd214 : 8'd144, QSORT ? 10'd856 : 10'd576};
        tbl[2]  = '{"all_busy",   1'b1, 7'b1111111, mk6(5,9,9,3,9,1,0), -1, 5'd0, 4'sd0,
                    -1, 1'b1, 8'd0, 10'd0};
        tbl[3]  = '{"not_valid",  1'b0, 7'b0000000, mk6(5,9,9,3,9,1,0), -1, 5'd0, 4'sd0,
                    -1, 1'b0, 8'd0, 10'd0};
        tbl[4]  = '{"lsb_ignored",1'b1, 7'b0000000, mk6(0,0,7,7,0,0,0), -1, 5'd0, 4'sd0,
                    QSORT ? 6 : 2, 1'b0, QSORT ? 8'd214 : 8'd74, QSORT ? 10'd856 : 10'd296};
        tbl[5]  = '{"clamp_zero", 1'b1, 7'b1111110, mk6(0,0,0,0,0,0,0), 0, 5'd0, -4'sd3,
                    0, 1'b0, 8'd0, 10'd0};
        tbl[6]  = '{"clamp_511",  1'b1, 7'b1110111, mk6(0,0,0,0,0,0,0), 3, 5'd31, 4'sd6,
                    3, 1'b0, 8'd127, 10'd511};
        tbl[7]  = '{"clamp_512",  1'b1, 7'b1101111, mk6(0,0,0,0,0,0,0), 4, 5'd1, -4'sd8,
                    4, 1'b0, 8'd129, 10'd512};
        tbl[8]  = '{"clamp_895",  1'b1, 7'b0111111, mk6(0,0,0,0,0,0,0), 6, 5'd31, 4'sd7,
                    6, 1'b0, 8'd223, 10'd895};
        tbl[9]  = '{"sub_198",    1'b1, 7'b1111101, mk6(0,0,0,0,0,0,0), 1, 5'd18, -4'sd2,
                    1, 1'b0, 8'd50, 10'd198};
        tbl[10] = '{"tie_first_free", 1'b1, 7'b0000001, mk6(9,9,9,9,9,9,9), -1, 5'd0, 4'sd0,
                    QSORT ? 6 : 1, 1'b0, QSORT ? 8'd214 : 8'd39, QSORT ? 10'd856 : 10'd156};
        tbl[11] = '{"upper_651",  1'b1, 7'b1011111, mk6(0,0,0,0,0,0,0), 5, 5'd2, 4'sd3,
                    5, 1'b0, 8'd162, 10'd651};

        global_reset = 1'b1;
        drive_base(1'b1, 7'b0000000, mk6(5,9,9,3,9,1,0), -1, 5'd0, 4'sd0);
        @(posedge clock);
        #1;
        // Reset held 3 clocks with valid_in high: outputs stay cleared.
        for (int k = 0; k < 3; k++) step('0, 1'b1, "reset_hold");

        // Directed table, streamed back-to-back.
        for (int v = 0; v < 12; v++) begin
            drive_base(tbl[v].vin, tbl[v].bsy, tbl[v].p6, tbl[v].och, tbl[v].okey, tbl[v].ooffs);
            e = '0;
            e.vld = tbl[v].vin;
            e.bsy = tbl[v].ebsy;
            if (tbl[v].vin && tbl[v].eidx >= 0) begin
                e.pat   = {tbl[v].p6[tbl[v].eidx*6 +: 6], 1'(tbl[v].eidx % 2)};
                e.key   = tbl[v].ekey;
                e.qlt   = 6'(10 + tbl[v].eidx);
                e.bend  = 5'(tbl[v].eidx + 1);
                e.carry = 12'(100 * tbl[v].eidx + 7);
                e.sub   = tbl[v].esub;
            end
            step(e, 1'b0, tbl[v].nm);
        end

        // Random back-to-back crossings against the reference model.
        for (int n = 0; n < 200; n++) begin
            drive_rand();
            step(model(), 1'b0, "stream");
        end

        // Reset with three crossings in flight; they must never emerge.
        for (int n = 0; n < 3; n++) begin
            drive_rand();
            valid_in = 1'b1;
            step(model(), 1'b0, "inflight");
        end
        drive_rand();
        valid_in = 1'b1;
        step('0, 1'b1, "mid_reset");
        for (int n = 0; n < 20; n++) begin
            drive_rand();
            step(model(), 1'b0, "resume");
        end

        // Drain the pipeline.
        valid_in = 1'b0;
        for (int n = 0; n < LAT; n++) step('0, 1'b0, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/best_1ofn_busy_pipe.md
# best_1ofn_busy_pipe

Pipelined, parametrised successor to the combinational 1-of-7 half-strip pattern selector. The block takes NCH candidate patterns per bunch crossing, each with a busy flag. It selects the highest-ranked non-busy candidate through a registered binary tournament tree, then emits the winner with its extended key and a boundary-clamped sub-strip key. It sits between the per-CFEB pattern finders and the CLCT builder, and accepts a new crossing every clock.

## Interface
- NCH, 7: number of candidate channels (2..16).
- IDXB, 3: channel-index bits, ≥ ceil(log2 NCH).
- MXPATB, 7: pattern-id width; bit 0 is bend direction and is never sorted on.
- MXKEYB, 5: per-channel key width.
- MXKEYBX, 8: extended key width, {idx,key}; must equal IDXB+MXKEYB.
- MXOFFSB, 4: signed sub-strip offset width.
- MXQLTB, 6: quality width.
- MXBNDB, 5: bend width.
- MXPATC, 12: comparator-code (carry) width.
- MXSUBKEYBX, 10: sub-key width.
- SPLIT_KEY, 128: first extended key of the upper region.
- KEY_MAX, 223: last valid extended key.

Ports:
- clock  in  1  system clock.
- global_reset  in  1  synchronous, active-high reset.
- valid_in  in  1  candidate set on the inputs is valid this cycle.
- pat  in  NCH*MXPATB  packed pattern ids; channel i is at [i*MXPATB +: MXPATB].
- key  in  NCH*MXKEYB  packed keys.
- offs  in  NCH*MXOFFSB  packed signed offsets.
- qlt  in  NCH*MXQLTB  packed qualities.
- bend  in  NCH*MXBNDB  packed bends.
- carry  in  NCH*MXPATC  packed carry codes.
- bsy  in  NCH  per-channel busy flags.
- valid_out  out  1  result valid.
- best_pat  out  MXPATB  winning pattern.
- best_key  out  MXKEYBX  {winner index, winner key}.
- best_qlt  out  MXQLTB  winner quality.
- best_bend  out  MXBNDB  winner bend.
- best_carry  out  MXPATC  winner carry.
- best_subkey  out  MXSUBKEYBX  clamped sub-strip key.
- best_bsy  out  1  all channels busy on a valid crossing.

## Operation
- Stage S0 registers all inputs and valid_in. Each channel carries `live = !bsy[i]` and its sort key.
- Tree stages S1..SD, where D = ceil(log2 NCH), compare pairs (lower index a, higher index b) at each level.
  - b wins iff b.live && (!a.live || sort(b) > sort(a)); otherwise a wins.
  - The surviving node is live if either input was live.
  - An odd node at a level passes through unchanged. Padding nodes are not live.
- Net rule: the winner is the maximum sort key among non-busy channels; ties go to the lowest index.
- The winner index is carried through the tree and prefixed onto key as best_key = {idx, key}.
- Final stage SF:
  - raw = 4*signed(best_key) + signed(offs), evaluated at MXSUBKEYBX+2 bits signed.
  - If best_key < SPLIT_KEY, clamp raw to [0, 4*SPLIT_KEY-1].
  - Otherwise clamp raw to [4*SPLIT_KEY, 4*KEY_MAX+3].
- If no channel is live: best_pat, best_key, best_qlt, best_bend, best_carry and best_subkey are 0, and best_bsy=1.
- If the crossing is not valid: best_bsy=0 and all data outputs are 0.

## Timing
- Latency from valid_in to valid_out is D+2 clocks; NCH=7 gives 5. Throughput is 1 crossing per clock, with no stall.
- valid propagates alongside the data. Each crossing is independent and carries no state across crossings.
- global_reset clears every pipeline register:
  - valid_out=0, best_bsy=0, all data outputs 0 on the next edge.
  - Crossings in flight are dropped, and no valid_out is produced for them.
  - valid_in sampled while global_reset=1 is ignored.
- Busy flags are sampled only in S0, so a change after sampling does not affect the crossing already in flight.

## Configuration
- SORT_ON_QLT_EN defined: the sort key is qlt (MXQLTB bits).
- SORT_ON_QLT_EN undefined: the sort key is pat[MXPATB-1:1]; the bend-direction LSB is ignored.
- The macro changes only the sort key; all other outputs and behaviour are the same either way.

## Test plan
- Reset: hold global_reset 3 clocks with valid_in=1 → valid_out=0, all outputs 0. Release → first valid_out exactly D+2 clocks after the first post-reset valid_in.
- Priority and tie: NCH=7, pat[6:1] = {5,9,9,3,9,1,0} for channels 0..6, none busy, macro off → best_key[7:5]=1, best_pat = channel 1 pattern.
- Busy skip: the case above with bsy[1]=bsy[2]=1 → winner is channel 4, best_key={3'd4,key4}, best_bsy=0. All bsy=1 → best_bsy=1, all data outputs 0.
- Sub-key clamping:
  - key=0, offs=-3 → best_subkey=0.
  - best_key=127, offs=+6 → 511.
  - best_key=129, offs=-8 → 512.
  - best_key=223, offs=+7 → 895.
  - best_key=50, offs=-2 → 198.
- Streaming: 200 back-to-back random crossings with random bsy, compared against a reference model delayed D+2 → every output matches each cycle. Repeat with the macro defined, and for NCH=2, 5 and 16.
- Reset mid-stream: assert global_reset for 1 clock while 3 crossings are in flight → none of them emerge, and the stream resumes correctly afterwards.
